// File: rtl/imm_packer.sv
// LEGv8 immediate packer: range/alignment-checks an immediate and inserts it into an instruction template.
// Two-stage valid/ready pipeline. Optional clamp of out-of-range values enabled by macro IMM_SATURATE_EN.
module imm_packer #(
    parameter int ERR_CNT_W = 16
) (
    input  logic                 CLK,
    input  logic                 ResetL,
    input  logic                 InValid,
    output logic                 InReady,
    input  logic [1:0]           Ctrl,
    input  logic [63:0]          Imm64,
    input  logic [31:0]          Template,
    output logic                 OutValid,
    input  logic                 OutReady,
    output logic [31:0]          Instr,
    output logic                 Err,
    output logic [ERR_CNT_W-1:0] ErrCount
);

    typedef enum logic [1:0] {
        FIELD_I   = 2'b00,
        FIELD_D   = 2'b01,
        FIELD_B   = 2'b10,
        FIELD_CBZ = 2'b11
    } fieldKind_t;

    logic       readyEn;
    logic       s1Valid;
    fieldKind_t s1Kind;
    logic [31:0] s1Template;
    logic [25:0] s1Field;
    logic       s1Err;
    logic       s2Load;

    logic [25:0] fieldNext;
    logic       rangeBad;
    logic       misaligned;
    logic       dFits;
    logic       bFits;
    logic       cbzFits;
    logic [31:0] packedWord;

    // Signed fields are legal when every bit above the field's sign bit matches Imm64[63].
    assign dFits   = (Imm64[63:8]  == {56{Imm64[63]}});
    assign bFits   = (Imm64[63:27] == {37{Imm64[63]}});
    assign cbzFits = (Imm64[63:20] == {44{Imm64[63]}});

    assign s2Load  = !OutValid || OutReady;
    assign InReady = readyEn && (!s1Valid || s2Load);

    always_comb begin
        fieldNext  = '0;
        rangeBad   = 1'b0;
        misaligned = 1'b0;
        case (fieldKind_t'(Ctrl))
            FIELD_I: begin
                rangeBad  = |Imm64[63:12];
                fieldNext = {14'd0, Imm64[11:0]};
`ifdef IMM_SATURATE_EN
                if (rangeBad) fieldNext = {14'd0, 12'hFFF};
`endif
            end
            FIELD_D: begin
                rangeBad  = !dFits;
                fieldNext = {17'd0, Imm64[8:0]};
`ifdef IMM_SATURATE_EN
                if (rangeBad) fieldNext = {17'd0, (Imm64[63] ? 9'h100 : 9'h0FF)};
`endif
            end
            FIELD_B: begin
                rangeBad   = !bFits;
                misaligned = |Imm64[1:0];
                fieldNext  = Imm64[27:2];
`ifdef IMM_SATURATE_EN
                if (rangeBad) fieldNext = Imm64[63] ? 26'h2000000 : 26'h1FFFFFF;
`endif
            end
            FIELD_CBZ: begin
                rangeBad   = !cbzFits;
                misaligned = |Imm64[1:0];
                fieldNext  = {7'd0, Imm64[20:2]};
`ifdef IMM_SATURATE_EN
                if (rangeBad) fieldNext = {7'd0, (Imm64[63] ? 19'h40000 : 19'h3FFFF)};
`endif
            end
            default: ;
        endcase
    end

    // Splice the registered field into the template, keeping all bits outside the field.
    always_comb begin
        packedWord = s1Template;
        case (s1Kind)
            FIELD_I:   packedWord = {s1Template[31:22], s1Field[11:0], s1Template[9:0]};
            FIELD_D:   packedWord = {s1Template[31:21], s1Field[8:0], s1Template[11:0]};
            FIELD_B:   packedWord = {s1Template[31:26], s1Field[25:0]};
            FIELD_CBZ: packedWord = {s1Template[31:24], s1Field[18:0], s1Template[4:0]};
            default:   packedWord = s1Template;
        endcase
    end

    always_ff @(posedge CLK or negedge ResetL) begin
        if (!ResetL) begin
            readyEn    <= 1'b0;
            s1Valid    <= 1'b0;
            s1Kind     <= FIELD_I;
            s1Template <= '0;
            s1Field    <= '0;
            s1Err      <= 1'b0;
        end else begin
            readyEn <= 1'b1;
            if (InReady) begin
                s1Valid <= InValid;
                if (InValid) begin
                    s1Kind     <= fieldKind_t'(Ctrl);
                    s1Template <= Template;
                    s1Field    <= fieldNext;
                    s1Err      <= rangeBad || misaligned;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge ResetL) begin
        if (!ResetL) begin
            OutValid <= 1'b0;
            Instr    <= '0;
            Err      <= 1'b0;
        end else if (s2Load) begin
            OutValid <= s1Valid;
            if (s1Valid) begin
                Instr <= packedWord;
                Err   <= s1Err;
            end
        end
    end

    // Counts delivered error beats; sticks at all-ones instead of wrapping.
    always_ff @(posedge CLK or negedge ResetL) begin
        if (!ResetL) begin
            ErrCount <= '0;
        end else if (OutValid && OutReady && Err && !(&ErrCount)) begin
            ErrCount <= ErrCount + ERR_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_imm_packer.sv
// Self-checking bench for imm_packer: directed spec vectors, backpressure, reset and a randomized scoreboard run.
// Honours IMM_SATURATE_EN in its reference model when the macro is defined.
module tb_imm_packer;

    localparam int CW = 3;
    localparam int ERR_MAX = (1 << CW) - 1;
`ifdef IMM_SATURATE_EN
    localparam logic [31:0] I_OVER_EXP = 32'h913FFC00;
`else
    localparam logic [31:0] I_OVER_EXP = 32'h91000000;
`endif

    typedef struct {
        logic [31:0] instr;
        logic        err;
    } beat_t;

    logic          CLK;
    logic          ResetL;
    logic          InValid;
    logic          InReady;
    logic [1:0]    Ctrl;
    logic [63:0]   Imm64;
    logic [31:0]   Template;
    logic          OutValid;
    logic          OutReady;
    logic [31:0]   Instr;
    logic          Err;
    logic [CW-1:0] ErrCount;

    int    testsRun;
    int    testsFailed;
    int    expErrCount;
    beat_t expQ[$];

    imm_packer #(.ERR_CNT_W(CW)) dut (
        .CLK(CLK), .ResetL(ResetL), .InValid(InValid), .InReady(InReady),
        .Ctrl(Ctrl), .Imm64(Imm64), .Template(Template),
        .OutValid(OutValid), .OutReady(OutReady), .Instr(Instr), .Err(Err),
        .ErrCount(ErrCount)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: legality from signed numeric ranges, field from shift-and-mask arithmetic.
    function automatic beat_t refModel(input logic [1:0] c, input logic [63:0] imm, input logic [31:0] t);
        beat_t       b;
        longint      v;
        int          lsb, width, shr;
        logic        inRange, aligned;
        logic [63:0] mask, field;
        v = longint'(imm);
        aligned = 1'b1;
        case (c)
            2'd0: begin lsb = 10; width = 12; shr = 0; inRange = (imm < 64'h1000); end
            2'd1: begin lsb = 12; width = 9;  shr = 0; inRange = (v >= -256 && v <= 255); end
            2'd2: begin lsb = 0;  width = 26; shr = 2; inRange = (v >= -134217728 && v <= 134217727);
                        aligned = (imm % 4 == 0); end
            default: begin lsb = 5; width = 19; shr = 2; inRange = (v >= -1048576 && v <= 1048575);
                        aligned = (imm % 4 == 0); end
        endcase
        mask  = (64'd1 << width) - 64'd1;
        field = (imm >> shr) & mask;
`ifdef IMM_SATURATE_EN
        if (!inRange) begin
            if (c == 2'd0)  field = mask;
            else if (v < 0) field = 64'd1 << (width - 1);
            else            field = mask >> 1;
        end
`endif
        b.instr = (t & ~32'(mask << lsb)) | 32'(field << lsb);
        b.err   = !(inRange && aligned);
        return b;
    endfunction

    function automatic logic [63:0] randImm();
        logic [63:0] r;
        int sel;
        sel = int'($urandom_range(0, 3));
        case (sel)
            0: r = {$urandom, $urandom};
            1: r = 64'(longint'($urandom_range(0, 8191)) - 64'sd4096);
            2: r = 64'(longint'($urandom_range(0, 4194303)) - 64'sd2097152);
            default: r = 64'(longint'($urandom_range(0, 536870911)) - 64'sd268435456);
        endcase
        if ($urandom_range(0, 1) == 1) r[1:0] = 2'b00;
        return r;
    endfunction

    task automatic step(input logic v, input logic [1:0] c, input logic [63:0] imm,
                        input logic [31:0] t, input logic ordy);
        @(negedge CLK);
        InValid  = v;
        Ctrl     = c;
        Imm64    = imm;
        Template = t;
        OutReady = ordy;
        #1;
    endtask

    task automatic test_reset();
        ResetL = 1'b0; InValid = 1'b0; OutReady = 1'b0;
        Ctrl = 2'd0; Imm64 = '0; Template = '0;
        #3;
        testsRun++;
        if (OutValid !== 1'b0 || Instr !== 32'd0 || Err !== 1'b0 || ErrCount !== '0 || InReady !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_state: got v=%b i=%h e=%b c=%0d r=%b expected all zero",
                     OutValid, Instr, Err, ErrCount, InReady);
        end
        @(posedge CLK);
        @(negedge CLK);
        ResetL = 1'b1;
        #1;
        testsRun++;
        if (InReady !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL ready_before_edge: got %b expected 0", InReady);
        end
        @(posedge CLK);
        #1;
        testsRun++;
        if (InReady !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL ready_after_edge: got %b expected 1", InReady);
        end
        expErrCount = 0;
    endtask

    task automatic test_latency();
        step(1'b1, 2'd0, 64'h123, 32'h91000000, 1'b1);
        testsRun++;
        if (InReady !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL lat_accept: got %b expected 1", InReady);
        end
        step(1'b0, 2'd0, 64'h0, 32'h0, 1'b1);
        testsRun++;
        if (OutValid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL lat_cycle1: got OutValid=%b expected 0", OutValid);
        end
        step(1'b0, 2'd0, 64'h0, 32'h0, 1'b1);
        testsRun++;
        if (OutValid !== 1'b1 || Instr !== 32'h91048C00 || Err !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL lat_cycle2: got v=%b i=%h e=%b expected v=1 i=91048c00 e=0",
                     OutValid, Instr, Err);
        end
        step(1'b0, 2'd0, 64'h0, 32'h0, 1'b1);
        testsRun++;
        if (OutValid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL lat_single: got OutValid=%b expected 0", OutValid);
        end
    endtask

    task automatic test_directed();
        logic [1:0]  cv[6] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd0, 2'd1};
        logic [63:0] iv[6] = '{-64'sd8, -64'sd4, 64'd8, 64'd6, 64'h1000, 64'd256};
        logic [31:0] tv[6] = '{32'hF8400000, 32'h14000000, 32'hB4000003, 32'hB4000003,
                               32'h91000000, 32'hF8400000};
        logic [31:0] ev[6];
        logic        er[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        bit          got;
        ev[0] = 32'hF85F8000; ev[1] = 32'h17FFFFFF; ev[2] = 32'hB4000043;
        ev[3] = 32'hB4000023; ev[4] = I_OVER_EXP;   ev[5] = refModel(2'd1, 64'd256, 32'hF8400000).instr;
        for (int n = 0; n < 6; n++) begin
            step(1'b1, cv[n], iv[n], tv[n], 1'b1);
            testsRun++;
            if (InReady !== 1'b1) begin
                testsFailed++;
                $display("[TB] FAIL dir%0d_accept: got %b expected 1", n, InReady);
            end
            got = 1'b0;
            for (int k = 0; k < 4 && !got; k++) begin
                step(1'b0, 2'd0, 64'h0, 32'h0, 1'b1);
                if (OutValid === 1'b1) begin
                    got = 1'b1;
                    testsRun++;
                    if (Instr !== ev[n] || Err !== er[n]) begin
                        testsFailed++;
                        $display("[TB] FAIL dir%0d_out: got i=%h e=%b expected i=%h e=%b",
                                 n, Instr, Err, ev[n], er[n]);
                    end
                    if (er[n]) expErrCount++;
                end
            end
            testsRun++;
            if (!got) begin
                testsFailed++;
                $display("[TB] FAIL dir%0d_timeout: got no OutValid expected one beat", n);
            end
            step(1'b0, 2'd0, 64'h0, 32'h0, 1'b1);
            testsRun++;
            if (ErrCount !== CW'(expErrCount) || OutValid !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL dir%0d_count: got cnt=%0d v=%b expected cnt=%0d v=0",
                         n, ErrCount, OutValid, expErrCount);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [1:0]  cv[3] = '{2'd0, 2'd1, 2'd3};
        logic [63:0] iv[3] = '{64'h55, 64'h10, -64'sd16};
        logic [31:0] tv[3] = '{32'h91000000, 32'hF8400000, 32'hB4000007};
        int    i, recv;
        beat_t b;
        i = 0; recv = 0;
        expQ.delete();
        for (int cyc = 0; cyc < 6; cyc++) begin
            step(i < 3, cv[i % 3], iv[i % 3], tv[i % 3], 1'b0);
            if (OutValid === 1'b1) begin
                testsRun++;
                if (Instr !== expQ[0].instr || Err !== expQ[0].err) begin
                    testsFailed++;
                    $display("[TB] FAIL bp_hold: got i=%h e=%b expected i=%h e=%b",
                             Instr, Err, expQ[0].instr, expQ[0].err);
                end
            end
            if (InValid && InReady) begin
                expQ.push_back(refModel(cv[i], iv[i], tv[i]));
                i++;
            end
        end
        testsRun++;
        if (i != 2 || InReady !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL bp_stall: got accepted=%0d ready=%b expected accepted=2 ready=0", i, InReady);
        end
        for (int cyc = 0; cyc < 15 && recv < 3; cyc++) begin
            step(i < 3, cv[i % 3], iv[i % 3], tv[i % 3], 1'b1);
            if (OutValid && OutReady) begin
                recv++;
                testsRun++;
                if (expQ.size() == 0) begin
                    testsFailed++;
                    $display("[TB] FAIL bp_extra: got i=%h expected no beat", Instr);
                end else begin
                    b = expQ.pop_front();
                    if (Instr !== b.instr || Err !== b.err) begin
                        testsFailed++;
                        $display("[TB] FAIL bp_order: got i=%h e=%b expected i=%h e=%b",
                                 Instr, Err, b.instr, b.err);
                    end
                end
            end
            if (InValid && InReady) begin
                expQ.push_back(refModel(cv[i], iv[i], tv[i]));
                i++;
            end
        end
        for (int cyc = 0; cyc < 3; cyc++) step(1'b0, 2'd0, 64'h0, 32'h0, 1'b1);
        testsRun++;
        if (recv != 3 || OutValid !== 1'b0 || expQ.size() != 0) begin
            testsFailed++;
            $display("[TB] FAIL bp_drain: got recv=%0d v=%b left=%0d expected recv=3 v=0 left=0",
                     recv, OutValid, expQ.size());
        end
    endtask

    task automatic test_random();
        beat_t       b;
        logic [31:0] prevInstr;
        logic        prevErr, prevStall;
        logic [1:0]  c;
        logic [63:0] imm;
        logic [31:0] t;
        expQ.delete();
        prevStall = 1'b0; prevInstr = '0; prevErr = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            c = 2'($urandom_range(0, 3));
            imm = randImm();
            t = $urandom;
            step((cyc < 580) && ($urandom_range(0, 3) != 0), c, imm, t, $urandom_range(0, 3) != 0);
            testsRun++;
            if (ErrCount !== CW'(expErrCount)) begin
                testsFailed++;
                $display("[TB] FAIL rnd_count: got %0d expected %0d", ErrCount, expErrCount);
            end
            if (prevStall) begin
                testsRun++;
                if (OutValid !== 1'b1 || Instr !== prevInstr || Err !== prevErr) begin
                    testsFailed++;
                    $display("[TB] FAIL rnd_stable: got v=%b i=%h e=%b expected v=1 i=%h e=%b",
                             OutValid, Instr, Err, prevInstr, prevErr);
                end
            end
            if (OutValid && OutReady) begin
                testsRun++;
                if (expQ.size() == 0) begin
                    testsFailed++;
                    $display("[TB] FAIL rnd_extra: got i=%h expected no beat", Instr);
                end else begin
                    b = expQ.pop_front();
                    if (Instr !== b.instr || Err !== b.err) begin
                        testsFailed++;
                        $display("[TB] FAIL rnd_beat: got i=%h e=%b expected i=%h e=%b",
                                 Instr, Err, b.instr, b.err);
                    end
                    if (b.err && expErrCount < ERR_MAX) expErrCount++;
                end
            end
            prevStall = OutValid && !OutReady;
            prevInstr = Instr;
            prevErr   = Err;
            if (InValid && InReady) expQ.push_back(refModel(c, imm, t));
        end
        for (int cyc = 0; cyc < 4; cyc++) step(1'b0, 2'd0, 64'h0, 32'h0, 1'b1);
        testsRun++;
        if (expQ.size() != 0 || ErrCount !== CW'(expErrCount)) begin
            testsFailed++;
            $display("[TB] FAIL rnd_drain: got left=%0d cnt=%0d expected left=0 cnt=%0d",
                     expQ.size(), ErrCount, expErrCount);
        end
    endtask

    task automatic test_reset_midflight();
        step(1'b1, 2'd0, 64'h1000, 32'h91000000, 1'b0);
        step(1'b1, 2'd3, 64'd6, 32'hB4000000, 1'b0);
        step(1'b1, 2'd3, 64'd7, 32'hB4000000, 1'b0);
        testsRun++;
        if (OutValid !== 1'b1 || InReady !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL rst_fill: got v=%b r=%b expected v=1 r=0", OutValid, InReady);
        end
        #1;
        ResetL = 1'b0;
        #1;
        testsRun++;
        if (OutValid !== 1'b0 || ErrCount !== '0 || InReady !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL rst_async: got v=%b cnt=%0d r=%b expected 0 0 0", OutValid, ErrCount, InReady);
        end
        expErrCount = 0;
        @(posedge CLK);
        @(negedge CLK);
        ResetL = 1'b1;
        for (int cyc = 0; cyc < 5; cyc++) begin
            step(1'b0, 2'd0, 64'h0, 32'h0, 1'b1);
            testsRun++;
            if (OutValid !== 1'b0 || ErrCount !== '0) begin
                testsFailed++;
                $display("[TB] FAIL rst_stale%0d: got v=%b cnt=%0d expected v=0 cnt=0", cyc, OutValid, ErrCount);
            end
        end
        testsRun++;
        if (InReady !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL rst_ready: got %b expected 1", InReady);
        end
    endtask

    initial begin
        testsRun = 0;
        testsFailed = 0;
        expErrCount = 0;
        test_reset();
        test_latency();
        test_directed();
        test_backpressure();
        test_random();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
